// File: rtl/modn_div_ctrl.sv
// Programmable mod-N clock-enable divider with run/stop control and a handshaked
// ratio-update port; define MODN_DIV_CFG_ERR_EN to reject ratios below 2 via cfg_err.
module modn_div_ctrl #(
    parameter int W         = 8,
    parameter int DEFAULT_N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_ratio,
    output logic         cfg_ready,
    output logic         clk_out,
    output logic         tick,
    output logic         running,
    output logic [W-1:0] cur_ratio
`ifdef MODN_DIV_CFG_ERR_EN
    ,
    output logic         cfg_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2,
        S_STOP = 2'd3
    } state_t;

    localparam logic [W-1:0] DEF_RATIO = W'(DEFAULT_N);
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] TWO       = W'(2);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic [W-1:0] pend_q, pend_d;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;
    logic         hs, load, period_end, ratio_ok;
    logic [W-1:0] ratio_in;
    logic [W-1:0] high_len_d;

    always_comb begin
        hs         = cfg_valid && (state_q != S_PEND);
        period_end = (state_q != S_IDLE) && (cnt_q == ratio_q - ONE);
`ifdef MODN_DIV_CFG_ERR_EN
        ratio_ok = (cfg_ratio >= TWO);
        ratio_in = cfg_ratio;
`else
        ratio_ok = 1'b1;
        ratio_in = (cfg_ratio < TWO) ? TWO : cfg_ratio;
`endif
        load = hs && ratio_ok;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (load) ratio_d = ratio_in;
                if (en)   state_d = S_RUN;
            end
            // RUN and STOP differ only in how they got there; en decides each cycle.
            S_RUN, S_STOP: begin
                if (period_end) begin
                    cnt_d   = '0;
                    if (load) ratio_d = ratio_in;
                    state_d = en ? S_RUN : S_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (load) begin
                        pend_d  = ratio_in;
                        state_d = S_PEND;
                    end else begin
                        state_d = en ? S_RUN : S_STOP;
                    end
                end
            end
            S_PEND: begin
                if (period_end) begin
                    cnt_d   = '0;
                    ratio_d = pend_q;
                    state_d = en ? S_RUN : S_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so they are computed from the next-state values.
        high_len_d = ratio_d - (ratio_d >> 1);
        clk_out_d  = (state_d != S_IDLE) && (cnt_d < high_len_d);
        tick_d     = (state_d != S_IDLE) && (cnt_d == ratio_d - ONE);
    end

`ifdef MODN_DIV_CFG_ERR_EN
    logic cfg_err_q, cfg_err_d;
    assign cfg_err_d = hs && !ratio_ok;
    always_ff @(posedge clk) begin
        if (rst) cfg_err_q <= 1'b0;
        else     cfg_err_q <= cfg_err_d;
    end
    assign cfg_err = cfg_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ratio_q   <= DEF_RATIO;
            pend_q    <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign cfg_ready = (state_q != S_PEND);
    assign running   = (state_q != S_IDLE);
    assign cur_ratio = ratio_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_modn_div_ctrl.sv
// Bench for modn_div_ctrl: directed literal scenarios plus randomized traffic,
// all checked each cycle against an abstract period/pending-queue model.
module tb_modn_div_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, cfg_valid;
    logic [W-1:0] cfg_ratio;
    logic         cfg_ready, clk_out, tick, running;
    logic [W-1:0] cur_ratio;
`ifdef MODN_DIV_CFG_ERR_EN
    logic         cfg_err;
`endif

    modn_div_ctrl #(.W(W), .DEFAULT_N(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ratio (cfg_ratio),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running),
        .cur_ratio (cur_ratio)
`ifdef MODN_DIV_CFG_ERR_EN
        ,
        .cfg_err   (cfg_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Model: is a period in progress, position within it, ratio in effect,
    // and at most one ratio waiting for the next boundary.
    bit        m_live   = 1'b0;
    bit        m_active = 1'b0;
    int        m_pos    = 0;
    int        m_ratio  = 5;
    int        m_pend[$];
    bit        m_err    = 1'b0;
    bit [31:0] clk_hist  = '0;
    bit [31:0] tick_hist = '0;

    always @(posedge clk) begin : model_blk
        int r;
        bit hs;
        bit ok;
        if (rst) begin
            m_live   = 1'b1;
            m_active = 1'b0;
            m_pos    = 0;
            m_ratio  = 5;
            m_pend.delete();
            m_err    = 1'b0;
        end else if (m_live) begin
            hs = cfg_valid && (m_pend.size() == 0);
            r  = int'(cfg_ratio);
`ifdef MODN_DIV_CFG_ERR_EN
            ok    = hs && (r >= 2);
            m_err = hs && (r < 2);
`else
            ok = hs;
            if (r < 2) r = 2;
`endif
            if (!m_active) begin
                if (ok) m_ratio = r;
                if (en) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == m_ratio - 1) begin
                m_pos = 0;
                if (m_pend.size() > 0) m_ratio = m_pend.pop_front();
                else if (ok)           m_ratio = r;
                m_active = en;
            end else begin
                m_pos++;
                if (ok) m_pend.push_back(r);
            end
        end
        #1;
        if (m_live) begin
            check("clk_out",   int'(clk_out),   int'(m_active && (m_pos < (m_ratio + 1) / 2)));
            check("tick",      int'(tick),      int'(m_active && (m_pos == m_ratio - 1)));
            check("running",   int'(running),   int'(m_active));
            check("cfg_ready", int'(cfg_ready), int'(m_pend.size() == 0));
            check("cur_ratio", int'(cur_ratio), m_ratio);
`ifdef MODN_DIV_CFG_ERR_EN
            check("cfg_err",   int'(cfg_err),   int'(m_err));
`endif
        end
        clk_hist  = {clk_hist[30:0], clk_out};
        tick_hist = {tick_hist[30:0], tick};
    end

    task automatic cyc(input bit e, input bit v, input int r);
        en        = e;
        cfg_valid = v;
        cfg_ratio = W'(r);
        @(negedge clk);
    endtask

    task automatic cycn(input int n, input bit e);
        for (int i = 0; i < n; i++) cyc(e, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_cur_ratio", int'(cur_ratio), 5);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_running",   int'(running),   0);
        check("rst_clk_out",   int'(clk_out),   0);
        check("rst_tick",      int'(tick),      0);
        rst = 1'b0;

        // Start at N=5: two full periods.
        cycn(10, 1'b1);
        check("start_pattern", int'(clk_hist[9:0]),  'b1110011100);
        check("start_ticks",   int'(tick_hist[9:0]), 'b0000100001);
        check("start_ratio",   int'(cur_ratio), 5);

        // Offer 4 at cnt=1: current period still completes at 5.
        cycn(2, 1'b1);
        cyc(1'b1, 1'b1, 4);
        check("pend_ready_low", int'(cfg_ready), 0);
        cycn(10, 1'b1);
        check("midchange_pattern", int'(clk_hist[12:0]), 'b1110011001100);
        check("midchange_ratio",   int'(cur_ratio), 4);

        // Offer 8 in the period-end cycle: applied at once, never pending.
        cyc(1'b1, 1'b1, 8);
        check("boundary_ready", int'(cfg_ready), 1);
        cycn(7, 1'b1);
        check("boundary_pattern", int'(clk_hist[7:0]),  'b11110000);
        check("boundary_ticks",   int'(tick_hist[7:0]), 'b00000001);
        check("boundary_ratio",   int'(cur_ratio), 8);

        // Graceful stop at cnt=2, then stop/re-assert without a gap.
        cyc(1'b1, 1'b1, 5);
        cycn(2, 1'b1);
        cycn(3, 1'b0);
        check("stop_running", int'(running), 0);
        check("stop_clk_out", int'(clk_out), 0);
        check("stop_pattern", int'(clk_hist[5:0]), 'b111000);
        cycn(3, 1'b1);
        cycn(1, 1'b0);
        cycn(4, 1'b1);
        check("resume_pattern", int'(clk_hist[7:0]), 'b11100111);
        check("resume_running", int'(running), 1);

        // Reset while 7 is pending: 7 must never appear.
        cyc(1'b1, 1'b1, 7);
        check("pend7_ready", int'(cfg_ready), 0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 0);
        rst = 1'b0;
        check("rstpend_ratio",   int'(cur_ratio), 5);
        check("rstpend_running", int'(running),   0);
        check("rstpend_ready",   int'(cfg_ready), 1);
        cycn(10, 1'b1);
        check("rstpend_pattern", int'(clk_hist[9:0]), 'b1110011100);
        check("rstpend_ratio2",  int'(cur_ratio), 5);

        // Illegal ratio 1 offered in IDLE.
        rst = 1'b1;
        cyc(1'b0, 1'b0, 0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1);
`ifdef MODN_DIV_CFG_ERR_EN
        check("illegal_err",   int'(cfg_err),   1);
        check("illegal_ratio", int'(cur_ratio), 5);
        cycn(6, 1'b1);
        check("illegal_pattern", int'(clk_hist[5:0]), 'b111001);
`else
        check("illegal_ratio", int'(cur_ratio), 2);
        cycn(6, 1'b1);
        check("illegal_pattern", int'(clk_hist[5:0]), 'b101010);
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int r;
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) r = int'($urandom_range(0, 255));
            else                           r = int'($urandom_range(0, 12));
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/modn_div_ctrl.md
# modn_div_ctrl

Programmable synchronous mod-N clock divider with a run/stop controller and a handshaked ratio-update port. It generates a divided clock-enable waveform `clk_out` from `clk` and changes the divide ratio only at a period boundary, so no truncated or runt periods appear. It sits between the configuration logic and the fixed-ratio divider family (mod-5 and siblings), and replaces a hard-coded N with a runtime-sequenced one.

## Interface
- `W`, default 8: width of the ratio bus.
- `DEFAULT_N`, default 5: ratio loaded at reset; must satisfy 2 ≤ DEFAULT_N < 2^W.

Ports:
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset; synchronous, active-high.
- `en` input, 1 bit: run request; level-sensitive.
- `cfg_valid` input, 1 bit: a new ratio is offered.
- `cfg_ratio` input, W bits: the offered ratio N.
- `cfg_ready` output, 1 bit: the block can accept a ratio this cycle.
- `clk_out` output, 1 bit: the divided waveform, registered.
- `tick` output, 1 bit: one-cycle pulse in the last cycle of each period.
- `running` output, 1 bit: high whenever the state is not IDLE.
- `cur_ratio` output, W bits: the ratio currently in effect.
- `cfg_err` output, 1 bit: present only with `MODN_DIV_CFG_ERR_EN`.

## Operation
- A handshake occurs when `cfg_valid` and `cfg_ready` are both high at a rising edge.
- Internal state:
  - period counter `cnt`, W bits;
  - `pend_ratio`, a single pending slot;
  - FSM states IDLE, RUN, PEND, STOP.
- Waveform: `clk_out` is high while `cnt` < N − (N >> 1).
  - Duty for even N is 50%.
  - Duty for odd N is one extra high cycle; N=5 gives 3 high, 2 low.
- Period end is the cycle with `cnt` == `cur_ratio` − 1. In that cycle `tick` = 1. At the following edge `cnt` returns to 0.
- FSM transitions:
  - **IDLE** (`cnt`=0, `clk_out`=0):
    - `en`=1 → RUN, with `cnt`=0 and `clk_out`=1 after the edge.
    - A handshake in IDLE loads `cur_ratio` directly at that edge.
  - **RUN**:
    - Handshake with no period end in the same cycle → store in `pend_ratio`, go to PEND.
    - Handshake in a period-end cycle → load `cur_ratio` at that boundary, stay in RUN.
    - `en`=0 → STOP.
  - **PEND** (`cfg_ready`=0):
    - At period end, `cur_ratio` ← `pend_ratio`, `cnt` ← 0.
    - Next state is RUN if `en`=1, otherwise IDLE.
    - `en`=0 in PEND does not leave PEND. The period finishes and the pending ratio is applied.
  - **STOP**:
    - Finish the current period, then go to IDLE at period end.
    - `en`=1 again before period end → return to RUN with no break in the waveform.
    - A handshake in STOP behaves as in RUN: it is stored in the slot if not at period end, and the state becomes PEND.
- `en` dropping in the same cycle as a period end in RUN → go directly to IDLE. `clk_out`=0 from the next cycle.
- `cfg_ready` = 1 in IDLE, RUN and STOP; 0 in PEND.
- Reset mid-operation:
  - Any pending ratio is discarded.
  - `cur_ratio` returns to DEFAULT_N.
  - The FSM returns to IDLE at the first edge with `rst`=1.
- Width rule: `cnt` compares against `cur_ratio` − 1 at W bits. The maximum ratio is 2^W − 1.

## Timing
- Reset values:
  - `clk_out`=0, `tick`=0, `running`=0, `cfg_err`=0.
  - `cfg_ready`=1.
  - `cur_ratio`=DEFAULT_N.
  - `cnt`=0, state IDLE.
- Start latency: `en` sampled high at edge k → `clk_out`=1 and `running`=1 from edge k.
- Stop latency: `clk_out` falls to 0 no later than the boundary of the period in progress.
- Ratio change: the new N governs the period that starts at the next boundary. Outputs never show a period that is neither old-N nor new-N.
- `tick` and `clk_out` are registered outputs. `cfg_ready` is decoded from registered state only and has no combinational path from `cfg_valid`.

## Configuration
- `MODN_DIV_CFG_ERR_EN` defined:
  - An offered `cfg_ratio` < 2 is accepted by the handshake but discarded.
  - `cfg_err` pulses high for one cycle after the handshake edge.
  - State and `cur_ratio` are unchanged.
- `MODN_DIV_CFG_ERR_EN` not defined:
  - The `cfg_err` port is absent.
  - `cfg_ratio` values 0 and 1 are clamped to 2 before use.

## Test plan
- **Reset and start:** `rst`=1 for 2 cycles, then `en`=1 with DEFAULT_N=5 → `clk_out` follows the repeating pattern 1,1,1,0,0. `tick` is high on every 5th cycle. `cur_ratio`=5.
- **Change mid-period:** running at N=5, offer 4 at `cnt`=1 → `cfg_ready` is 0 until the boundary. The current period completes at 5 cycles. The next period has 4 cycles with pattern 1,1,0,0.
- **Change at boundary:** offer 8 in the period-end cycle → the next period is 8 cycles, 4 high and 4 low. The FSM never enters PEND.
- **Graceful stop:** drop `en` at `cnt`=2 with N=5 → the remaining 2 cycles complete, then `clk_out`=0 and `running`=0. Re-assert `en` before the boundary → there is no gap in the waveform.
- **Reset mid-PEND:** pending ratio 7, then `rst`=1 → `cur_ratio`=5, state IDLE, `cfg_ready`=1. The 7 is never applied.
- **Illegal ratio:** offer 1 → with the macro, `cfg_err` pulses and N stays 5. Without the macro, N becomes 2 and `clk_out` toggles every cycle.
